load_extend_unit: RTL
=====================

Name: load_extend_unit

Overview:
Registered load-data aligner and sign/zero extender for the LSU return path. It is the parametrised successor of the combinational extender. It takes raw memory read words plus the byte offset, access size and extension mode, and produces an XLEN-wide extended result. Valid/ready handshakes sit on both sides, with optional merging of misaligned two-beat accesses. It sits between the data-memory read port and the writeback mux.

Parameters:
XLEN, 32, datapath width in bits; legal values 32 or 64.
OFFW, $clog2(XLEN/8), byte-offset width; derived, not overridden.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input beat valid.
in_ready  output  1  unit accepts the beat this cycle.
in_data  input  XLEN  raw memory word.
in_offset  input  OFFW  byte offset of the access within in_data.
in_size  input  2  access size: 0=byte, 1=half, 2=word, 3=dword (dword legal only when XLEN=64).
in_uext  input  1  1=zero-extend, 0=sign-extend.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_data  output  XLEN  extended result.
out_err  output  1  qualifies out_valid; illegal size, or misaligned access when the feature is off.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_err=0, FSM=IDLE, partial-capture register cleared. in_ready=0 while rst_n is low.
- Transfer rules: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Output stage is a single register. in_ready = !out_valid || out_ready, so full throughput is possible with no bubble.
- Aligned access (offset + bytes(size) <= XLEN/8):
  - Field = in_data bits [8*offset +: 8<<size].
  - Upper bits are zero-filled if in_uext=1, otherwise filled with the field MSB.
  - Result is registered with latency 1 cycle (out_valid rises the edge after acceptance).
- Illegal size (3 when XLEN=32): result register loads out_data=0 and out_err=1. No FSM change.
- out_data and out_err hold stable while out_valid && !out_ready.
- FSM states: IDLE, WAIT_HI. WAIT_HI exists only with the optional feature.
  - IDLE -> WAIT_HI: an accepted beat is misaligned (offset + bytes(size) > XLEN/8).
  - WAIT_HI -> IDLE: the second beat is accepted.
- WAIT_HI behaviour:
  - Latch from the first beat: low bytes (in_data from offset upward), size, uext, and the byte count already captured.
  - Second beat supplies the remaining high bytes from its byte 0 upward. Its offset, size and uext are ignored.
  - Merged field is extended and registered. Latency is 1 cycle after the second beat.
  - out_valid stays 0 between the first and second beats.
- Simultaneous output drain and input accept in the same cycle: the new result replaces the old one; nothing is lost or duplicated.
- Reset asserted in WAIT_HI discards the partial capture. The next beat after reset is a new request.

Optional Feature:
Macro LOAD_EXTEND_MISALIGN_EN.
- Defined: misaligned accesses are merged across two beats through the WAIT_HI state as described above.
- Undefined: no WAIT_HI state. A misaligned access produces a single result with out_data=0 and out_err=1, 1 cycle latency, and the FSM stays in IDLE.

Test Plan:
1. XLEN=32, in_data=0x12345680, offset 0, size 0, uext 0 -> out_data=0xFFFFFF80 next cycle. Same input with uext 1 -> 0x00000080, out_err=0.
2. in_data=0x80011234, offset 2, size 1, uext 0 -> 0xFFFF8001. offset 0, size 1, uext 0 -> 0x00001234. size 2, uext 0 -> 0x80011234.
3. Backpressure: result valid and out_ready=0 for 3 cycles, with a second in_valid pending -> out_data stable, in_ready=0, second beat not consumed. Raise out_ready -> back-to-back results, no bubble.
4. With macro: offset 3, size 2, beat1=0xAA000000, beat2=0x00BBCCDD -> out_valid=0 after beat1, then out_data=0xBBCCDDAA, out_err=0. Without macro: beat1 alone -> out_data=0, out_err=1.
5. With macro: rst_n pulsed low while in WAIT_HI -> out_valid=0 immediately. The next aligned byte beat 0x000000FF with uext 1 -> 0x000000FF.
6. XLEN=32, size 3 -> out_err=1, out_data=0. XLEN=64, size 3, data 0x8000000000000001 -> 0x8000000000000001, out_err=0.

Source files
------------

// File: rtl/load_extend_unit.sv
// load_extend_unit
//   Registered load-data aligner and sign/zero extender on the LSU return path.
//   It sits between the data-memory read port and the writeback mux. Each beat
//   carries a raw memory word plus byte offset, access size and extension mode.
//   The unit produces an XLEN-wide extended result through a single output
//   register, with valid/ready handshakes on both sides.
//
//   Optional feature, macro LOAD_EXTEND_MISALIGN_EN:
//     defined   - a misaligned access is merged across two beats (WAIT_HI state).
//     undefined - a misaligned access returns out_data=0 with out_err=1.
//
// Parameters
//   XLEN : datapath width, 32 or 64.
//   OFFW : byte-offset width, derived from XLEN.
//
// Ports
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset.
//   in_valid/in_ready   : input beat handshake.
//   in_data             : raw memory word.
//   in_offset           : byte offset of the access within in_data.
//   in_size             : 0=byte, 1=half, 2=word, 3=dword (dword only for XLEN=64).
//   in_uext             : 1=zero-extend, 0=sign-extend.
//   out_valid/out_ready : result handshake.
//   out_data            : extended result.
//   out_err             : illegal size, or misaligned access with the feature off.
module load_extend_unit #(
   parameter int XLEN = 32,
   parameter int OFFW = $clog2(XLEN/8)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_data,
   input  logic [OFFW-1:0] in_offset,
   input  logic [1:0]      in_size,
   input  logic            in_uext,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic            out_err
);

   localparam int NB = XLEN/8;

`ifdef LOAD_EXTEND_MISALIGN_EN
   typedef enum logic [0:0] {IDLE = 1'b0, WAIT_HI = 1'b1} state_t;
`else
   typedef enum logic [0:0] {IDLE = 1'b0} state_t;
`endif

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      size_bytes = 4'd1 << size;
   endfunction

   function automatic logic size_legal(input logic [1:0] size);
      size_legal = (size != 2'd3) || (XLEN == 64);
   endfunction

   // field is already right-aligned; bytes above the access width are
   // replaced by the fill byte (zero, or copies of the field MSB)
   function automatic logic signed [XLEN-1:0] extend(input logic [XLEN-1:0] field,
                                                     input logic [1:0]      size,
                                                     input logic            uext);
      logic signed [XLEN-1:0] r;
      logic                   fill;
      fill = 1'b0;
      r    = field;
      for (int i = 0; i < NB; i++) begin
         if (i == int'(size_bytes(size)) - 1) fill = field[8*i+7] & ~uext;
      end
      for (int i = 0; i < NB; i++) begin
         if (i >= int'(size_bytes(size))) r[8*i +: 8] = {8{fill}};
      end
      return r;
   endfunction

   state_t                 state_q, state_d;
   logic                   in_fire, out_fire;
   logic                   load_p0, err_p0, misaligned_p0;
   logic signed [XLEN-1:0] res_p0;
   logic [XLEN-1:0]        shifted_p0;
   logic                   vld_p1, err_p1;
   logic [XLEN-1:0]        data_p1;

`ifdef LOAD_EXTEND_MISALIGN_EN
   logic                   capture_p0;
   logic [XLEN-1:0]        part_q;
   logic [OFFW-1:0]        pcnt_q;
   logic [1:0]             psize_q;
   logic                   puext_q;
`endif

   assign in_ready  = rst_n & (~vld_p1 | out_ready);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = vld_p1 & out_ready;
   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_err   = err_p1;

   // ---- stage p0: align, classify, extend ----
   always_comb begin
      state_d       = state_q;
      load_p0       = 1'b0;
      err_p0        = 1'b0;
      res_p0        = '0;
`ifdef LOAD_EXTEND_MISALIGN_EN
      capture_p0    = 1'b0;
`endif
      shifted_p0    = in_data >> {in_offset, 3'b000};
      misaligned_p0 = (int'(in_offset) + int'(size_bytes(in_size))) > NB;
      if (in_fire) begin
         if (state_q == IDLE) begin
            if (!size_legal(in_size)) begin
               load_p0 = 1'b1;
               err_p0  = 1'b1;
            end else if (misaligned_p0) begin
`ifdef LOAD_EXTEND_MISALIGN_EN
               capture_p0 = 1'b1;
               state_d    = WAIT_HI;
`else
               load_p0 = 1'b1;
               err_p0  = 1'b1;
`endif
            end else begin
               load_p0 = 1'b1;
               res_p0  = extend(shifted_p0, in_size, in_uext);
            end
         end
`ifdef LOAD_EXTEND_MISALIGN_EN
         else begin
            // second beat: its byte 0 lands just above the captured low bytes
            load_p0 = 1'b1;
            res_p0  = extend(part_q | (in_data << {pcnt_q, 3'b000}), psize_q, puext_q);
            state_d = IDLE;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

`ifdef LOAD_EXTEND_MISALIGN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         part_q  <= '0;
         pcnt_q  <= '0;
         psize_q <= '0;
         puext_q <= 1'b0;
      end else if (capture_p0) begin
         part_q  <= shifted_p0;
         pcnt_q  <= OFFW'(NB - int'(in_offset));
         psize_q <= in_size;
         puext_q <= in_uext;
      end
   end
`endif

   // ---- stage p1: output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         err_p1  <= 1'b0;
      end else if (load_p0) begin
         vld_p1  <= 1'b1;
         data_p1 <= res_p0;
         err_p1  <= err_p0;
      end else if (in_fire || out_fire) begin
         // first half of a split access, or a plain drain
         vld_p1 <= 1'b0;
      end
   end

endmodule
